// File: rtl/gpio_button_capture.sv
// gpio_button_capture: synchronised, debounced push-buttons with sticky press flags and a status read port
// Optional registered level interrupt when BTN_IRQ_EN is defined; otherwise irq is tied low.
module gpio_button_capture #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_raw,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] clr,
  output logic [15:0]      rd_data,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_pending,
  output logic             irq
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s0, s1, lvl, pending, done, rise;
  logic [CNT_W-1:0] cnt [WIDTH];
  always_comb begin
    done = '0;
    for (int i = 0; i < WIDTH; i++) done[i] = (s1[i] != lvl[i]) && (cnt[i] == LAST);
    rise = done & s1;
  end
  // set beats clear so a press landing on a clear pulse is never lost
  always_ff @(posedge clk)
    if (!rst) begin
      s0      <= '0;
      s1      <= '0;
      lvl     <= '0;
      pending <= '0;
      rd_data <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s0      <= btn_raw;
      s1      <= s0;
      lvl     <= lvl ^ done;
      pending <= rise | (pending & ~clr);
      if (rd_en) rd_data <= {8'h00, 8'(pending), 8'(lvl)};
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= (s1[i] == lvl[i] || done[i]) ? '0 : cnt[i] + CNT_W'(1);
    end
`ifdef BTN_IRQ_EN
  always_ff @(posedge clk)
    if (!rst) irq <= 1'b0;
    else irq <= |pending;
`else
  assign irq = 1'b0;
`endif
  assign btn_level   = lvl;
  assign btn_pending = pending;
endmodule

// File: tb/tb_gpio_button_capture.sv
// tb_gpio_button_capture: directed test-plan steps plus randomized traffic against a window-based reference model
module tb_gpio_button_capture;
  localparam int W = 4;
  localparam int DC = 4;
  logic clk = 0, rst = 0, rd_en = 0;
  logic [W-1:0] btn_raw = '0, clr = '0;
  logic [15:0] rd_data;
  logic [W-1:0] btn_level, btn_pending;
  logic irq;
  int tests = 0, fails = 0;
  gpio_button_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .rd_en(rd_en), .clr(clr),
    .rd_data(rd_data), .btn_level(btn_level), .btn_pending(btn_pending), .irq(irq));
  always #5 clk = ~clk;
  // model: a level flips once the synchronised input has disagreed with it for DC consecutive edges
  logic [W-1:0] m_d0, m_d1, m_lvl, m_pend;
  logic [15:0] m_rd;
  logic m_irq;
  logic [W-1:0] win[$];
  task automatic model_edge();
    logic [W-1:0] tog;
    if (!rst) begin
      m_d0 = '0; m_d1 = '0; m_lvl = '0; m_pend = '0; m_rd = '0; m_irq = 0;
      win.delete();
    end else begin
      m_irq = |m_pend;
      win.push_back(m_d1);
      if (win.size() > DC) void'(win.pop_front());
      tog = '0;
      if (win.size() == DC)
        for (int i = 0; i < W; i++) begin
          tog[i] = 1'b1;
          foreach (win[k]) if (win[k][i] == m_lvl[i]) tog[i] = 1'b0;
        end
      if (rd_en) m_rd = {8'h00, 8'(m_pend), 8'(m_lvl)};
      m_pend = (tog & ~m_lvl) | (m_pend & ~clr);
      m_lvl = m_lvl ^ tog;
      m_d1 = m_d0;
      m_d0 = btn_raw;
    end
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("level", 16'(btn_level), 16'(m_lvl));
    check("pending", 16'(btn_pending), 16'(m_pend));
    check("rd_data", rd_data, m_rd);
`ifdef BTN_IRQ_EN
    check("irq", 16'(irq), 16'(m_irq));
`else
    check("irq", 16'(irq), 16'h0);
`endif
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    rst = 0; btn_raw = 4'hF;
    steps(3);
    check("rst_level", 16'(btn_level), 16'h0);
    check("rst_rd", rd_data, 16'h0);
    rst = 1;
    steps(5);
    check("rst_lvl_e5", 16'(btn_level), 16'h0);
    step();
    check("rst_lvl_e6", 16'(btn_level), 16'hF);
    check("rst_pend_e6", 16'(btn_pending), 16'hF);
    rst = 0; btn_raw = '0;
    steps(2);
    rst = 1;
    step();
    btn_raw[1] = 1;
    steps(5);
    check("press_e5", 16'(btn_level), 16'h0);
    step();
    check("press_lvl", 16'(btn_level), 16'h2);
    check("press_pend", 16'(btn_pending), 16'h2);
    step();
`ifdef BTN_IRQ_EN
    check("press_irq", 16'(irq), 16'h1);
`endif
    rd_en = 1; step(); rd_en = 0;
    check("press_rd", rd_data, 16'h0202);
    btn_raw[0] = 1; steps(3);
    btn_raw[0] = 0; step();
    btn_raw[0] = 1; steps(5);
    check("bounce_e5", 16'(btn_level[0]), 16'h0);
    step();
    check("bounce_e6", 16'(btn_level[0]), 16'h1);
    check("bounce_pend", 16'(btn_pending), 16'h3);
    steps(2);
    clr = 4'b0001; step(); clr = '0;
    check("clr0_pend", 16'(btn_pending), 16'h2);
    step();
`ifdef BTN_IRQ_EN
    check("clr0_irq", 16'(irq), 16'h1);
`endif
    clr = 4'b0010; step(); clr = '0;
    check("clr1_pend", 16'(btn_pending), 16'h0);
    step();
    check("clr1_irq", 16'(irq), 16'h0);
    btn_raw[2] = 1; steps(5);
    clr = 4'b0100; step(); clr = '0;
    check("collide_lvl", 16'(btn_level[2]), 16'h1);
    check("collide_pend", 16'(btn_pending[2]), 16'h1);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) btn_raw[$urandom_range(0, W-1)] ^= 1'b1;
      rd_en = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 4) == 0) ? W'($urandom) : '0;
      rst = ($urandom_range(0, 80) != 0);
      step();
    end
    rst = 1; rd_en = 0; clr = '0;
    steps(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpio_button_capture.md
# gpio_button_capture

Input-conditioning stage between the board GPIO header and the CPU/VGA top level. Synchronises raw push-button lines (e.g. `gpio1[25]`), debounces them, latches press events as sticky pending bits, and presents level and pending status on a 16-bit read port for the 16-bit CPU's memory-mapped I/O. Optional level interrupt toward the CPU.

## Interface
Parameters:
- `WIDTH`, 4, number of button channels; legal range 1–8.
- `DEBOUNCE_CYCLES`, 500000, stable-sample count before a level change is accepted (10 ms at 50 MHz); minimum 2.
- `CNT_W`, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-low.
- `btn_raw`  in  WIDTH  asynchronous button inputs, 1 = pressed.
- `rd_en`  in  1  CPU read strobe for the status word.
- `clr`  in  WIDTH  write-1-to-clear strobe for pending bits; single-cycle pulses.
- `rd_data`  out  16  registered status word.
- `btn_level`  out  WIDTH  debounced button levels.
- `btn_pending`  out  WIDTH  sticky press-event flags.
- `irq`  out  1  interrupt request, active-high level.

## Operation
- Per channel: 2-flop synchroniser `s0 -> s1`, then debounce counter `cnt` and stable level `lvl`.
- Debounce, evaluated each cycle per channel:
  - `s1 == lvl`: `cnt <= 0`.
  - `s1 != lvl` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `s1 != lvl` and `cnt == DEBOUNCE_CYCLES-1`: `lvl <= s1`, `cnt <= 0`.
  - Any glitch back to `lvl` restarts the count from 0.
- Press detect: `lvl` 0->1 sets `pending` for that channel. Release (1->0) sets nothing.
- Clear: `clr[i]=1` clears `pending[i]` on the next edge. If set and clear coincide in the same cycle, set wins and pending stays 1.
- Read: when `rd_en=1`, `rd_data <= {8'b0, pending_pad, level_pad}`.
  - `rd_data[7:0]` is `lvl` zero-extended to 8 bits.
  - `rd_data[15:8]` is `pending` zero-extended to 8 bits.
  - The sampled values are the pre-edge register values.
  - When `rd_en=0`, `rd_data` holds its value.
  - Reads do not clear pending.
- Channels are fully independent. No cross-channel priority.

## Timing
- Reset (`rst=0` at a clock edge) clears all of the following; everything is 0 on the first edge with `rst=0`:
  - `s0`, `s1`, `cnt`, `lvl`, `pending`.
  - `rd_data`.
  - `irq`.
- Reset asserted mid-count discards the count. After release, a held button needs a full `2 + DEBOUNCE_CYCLES` cycles and then registers as a new press.
- Latency from a `btn_raw` change (stable thereafter) to a `btn_level` change is exactly `2 + DEBOUNCE_CYCLES` edges: 2 synchroniser edges plus `DEBOUNCE_CYCLES` counting edges, with the final edge updating `lvl`.
- `btn_pending` rises on the same edge as `btn_level`.
- `irq` rises one edge after `btn_pending`, because it is registered.
- `rd_data` is valid the edge after `rd_en`.
- `clr` to pending low: 1 edge. `irq` deasserts 1 edge later, provided no other pending bit is set.
- Counter never wraps: it saturates at `DEBOUNCE_CYCLES-1` only transiently, because that state always resolves to reset-to-0.

## Configuration
- Macro: `BTN_IRQ_EN`.
- Defined: `irq <= |pending` is registered each cycle.
- Undefined: `irq` is tied to constant 0 and the OR-reduce logic is not built. All other behaviour is identical.

## Test plan
Run with `DEBOUNCE_CYCLES=4`, `WIDTH=4`, `BTN_IRQ_EN` defined unless noted.
- Reset: hold `rst=0` for 3 cycles with `btn_raw=4'hF` -> all outputs are 0. After `rst=1`, `btn_level=4'hF` appears exactly 6 edges later, with `btn_pending=4'hF`.
- Clean press: `btn_raw[1]` goes 0->1 and holds -> `btn_level[1]=1` and `btn_pending[1]=1` on edge 6, `irq=1` on edge 7. Then `rd_en` pulse -> `rd_data=16'h0202`.
- Bounce: `btn_raw[0]` high for 3 cycles, low 1 cycle, then high and held -> no level change until 6 edges after the final rise. `btn_pending[0]` sets once.
- Clear: with `pending=4'b0011`, pulse `clr=4'b0001` -> `pending=4'b0010`, `irq` stays 1. Then pulse `clr=4'b0010` -> `pending=0`, `irq=0` one edge later.
- Set/clear collision: pulse `clr[2]` on the same edge `lvl[2]` rises -> `btn_pending[2]=1`.
- `BTN_IRQ_EN` undefined: repeat the clean-press test -> `irq` stays 0 throughout. `pending` and `rd_data` are unchanged from the defined case.
